// File: rtl/count_chk_pkg.sv
// Shared types and default parameters for the counter-bus checker.
package count_chk_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int unsigned WIDTH_DEF       = 8;
  localparam int unsigned STALL_LIMIT_DEF = 268435456;
  localparam int unsigned ERR_W_DEF       = 16;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with clock enable and synchronous clear.
// A clear and an increment on the same edge give 1 (clear first, then count).
module sat_counter #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  // Next count: optional clear, then a saturating increment on top of it.
  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && (base != MAX)) begin
      cnt_d = base + W'(1);
    end
  end

  // Count register; frozen while the enable is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Receive-side monitor for the LED counter bus: verifies every change of
// count_in is +1 (wrapping), reports lock, error count and stall.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF,
  parameter int unsigned ERR_W       = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stall,
  output logic [WIDTH-1:0] last_value
);

  localparam int unsigned    TW       = $clog2(STALL_LIMIT + 1);
  localparam logic [TW-1:0]  LIMIT    = TW'(STALL_LIMIT);
  localparam logic [TW-1:0]  LIMIT_M1 = TW'(STALL_LIMIT - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  prev_q;
  logic              primed_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic              stall_q;
  logic [TW-1:0]     timer_q;
  logic [ERR_W-1:0]  err_count_q;

  logic [WIDTH-1:0]  prev_inc;
  logic              change;
  logic              good;
  logic              tracking;
  logic              bad_evt;
  logic              tmr_clr;
  logic              tmr_inc;
  logic              stall_hit;

  // Transition classification against the last accepted value.
  always_comb begin
    prev_inc  = prev_q + WIDTH'(1);
    change    = (count_in != prev_q);
    good      = (count_in == prev_inc);
    tracking  = (state_q == TRACK);
    bad_evt   = tracking && change && !good;
    // Timer restarts on any accepted change in TRACK and on the lock-in change.
    tmr_clr   = change && (tracking || (primed_q && good));
    tmr_inc   = tracking && !change;
    stall_hit = tmr_inc && (timer_q == LIMIT_M1);
  end

  sat_counter #(
    .W   (ERR_W),
    .MAX ({ERR_W{1'b1}})
  ) u_err_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (clk_en),
    .clr_i (clr_err),
    .inc_i (bad_evt),
    .cnt_o (err_count_q)
  );

  sat_counter #(
    .W   (TW),
    .MAX (LIMIT)
  ) u_stall_tmr (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (clk_en),
    .clr_i (tmr_clr),
    .inc_i (tmr_inc),
    .cnt_o (timer_q)
  );

  // SYNC/TRACK state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      prev_q      <= '0;
      primed_q    <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      stall_q     <= 1'b0;
    end else if (clk_en) begin
      err_pulse_q <= bad_evt;
      unique case (state_q)
        SYNC: begin
          if (!primed_q) begin
            prev_q   <= count_in;
            primed_q <= 1'b1;
          end else if (change) begin
            prev_q <= count_in;
            if (good) begin
              state_q  <= TRACK;
              locked_q <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (change) begin
            prev_q <= count_in;
            if (!good) begin
              state_q  <= SYNC;
              locked_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= SYNC;
          locked_q <= 1'b0;
        end
      endcase
      // Stall assertion takes priority over a coincident clear.
      if (stall_hit) begin
        stall_q <= 1'b1;
      end else if (clr_err || (tracking && change && good)) begin
        stall_q <= 1'b0;
      end
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign stall      = stall_q;
  assign last_value = prev_q;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker (WIDTH=8, STALL_LIMIT=16, ERR_W=4).
module tb_count_checker;

  localparam int unsigned W   = 8;
  localparam int unsigned LIM = 16;
  localparam int unsigned EW  = 4;
  localparam int unsigned EMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic [W-1:0]  count_in = '0;
  logic          clr_err = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic [EW-1:0] err_count;
  logic          stall;
  logic [W-1:0]  last_value;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic          locked;
    logic          pulse;
    logic [EW-1:0] errc;
    logic          stall;
    logic [W-1:0]  last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state
  logic         m_track = 1'b0;
  logic         m_primed = 1'b0;
  logic [W-1:0] m_prev = '0;
  int unsigned  m_timer = 0;
  int unsigned  m_err = 0;
  logic         m_stall = 1'b0;
  logic         m_pulse = 1'b0;

  count_checker #(
    .WIDTH       (W),
    .STALL_LIMIT (LIM),
    .ERR_W       (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .count_in   (count_in),
    .clr_err    (clr_err),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .stall      (stall),
    .last_value (last_value)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural model of one clock edge, written from the block description.
  task automatic model_step(input logic r, input logic e, input logic c, input logic [W-1:0] v);
    logic         chg;
    logic         gd;
    logic [W-1:0] nxt;
    nxt = m_prev + 8'd1;
    chg = (v != m_prev);
    gd  = (v == nxt);
    if (r) begin
      m_track = 0; m_primed = 0; m_prev = '0; m_timer = 0;
      m_err = 0; m_stall = 0; m_pulse = 0;
    end else if (e) begin
      m_pulse = 0;
      if (c) begin
        m_err   = 0;
        m_stall = 0;
      end
      if (!m_track) begin
        if (!m_primed) begin
          m_prev = v; m_primed = 1;
        end else if (chg) begin
          m_prev = v;
          if (gd) begin m_track = 1; m_timer = 0; end
        end
      end else begin
        if (chg) begin
          m_prev = v; m_timer = 0;
          if (gd) m_stall = 0;
          else begin
            m_pulse = 1;
            if (m_err < EMAX) m_err = m_err + 1;
            m_track = 0;
          end
        end else if (m_timer < LIM) begin
          m_timer = m_timer + 1;
          if (m_timer == LIM) m_stall = 1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the model's expectation for it.
  task automatic step(input logic r, input logic e, input logic c, input logic [W-1:0] v);
    exp_t x;
    @(negedge clk);
    rst = r; clk_en = e; clr_err = c; count_in = v;
    model_step(r, e, c, v);
    x.locked = m_track;
    x.pulse  = m_pulse;
    x.errc   = EW'(m_err);
    x.stall  = m_stall;
    x.last   = m_prev;
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  // Scoreboard: compare every output after each edge against the queued model result.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks += 5;
      if (locked !== mon_e.locked) begin
        n_errors++; $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, locked, mon_e.locked);
      end
      if (err_pulse !== mon_e.pulse) begin
        n_errors++; $display("FAIL sb_err_pulse t=%0t got=%b exp=%b", $time, err_pulse, mon_e.pulse);
      end
      if (err_count !== mon_e.errc) begin
        n_errors++; $display("FAIL sb_err_count t=%0t got=%0d exp=%0d", $time, err_count, mon_e.errc);
      end
      if (stall !== mon_e.stall) begin
        n_errors++; $display("FAIL sb_stall t=%0t got=%b exp=%b", $time, stall, mon_e.stall);
      end
      if (last_value !== mon_e.last) begin
        n_errors++; $display("FAIL sb_last_value t=%0t got=%h exp=%h", $time, last_value, mon_e.last);
      end
    end
  end

  logic [W-1:0] v;

  task automatic test_reset();
    step(1, 1, 0, 8'h00);
    step(1, 0, 1, 8'h5A);
    #1;
    n_checks++;
    if ({locked, err_pulse, err_count, stall, last_value} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got=%b/%b/%0d/%b/%h exp=all zero", locked, err_pulse, err_count, stall, last_value);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    #1; n_checks++;
    if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_before got=%b exp=0", locked); end
    step(0, 1, 0, 8'h01);
    #1; n_checks++;
    if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_at_first_inc got=%b exp=1", locked); end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h01);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h02);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h03);
    #1; n_checks += 2;
    if (err_count !== 4'd0) begin n_errors++; $display("FAIL lock_errcnt got=%0d exp=0", err_count); end
    if (last_value !== 8'h03) begin n_errors++; $display("FAIL lock_last got=%h exp=03", last_value); end
  endtask

  // Back-to-back increments every cycle through the 0xFF->0x00 wrap.
  task automatic test_wrap_back_to_back();
    for (int unsigned i = 4; i <= 256; i++) step(0, 1, 0, W'(i));
    #1; n_checks += 3;
    if (locked !== 1'b1) begin n_errors++; $display("FAIL wrap_locked got=%b exp=1", locked); end
    if (last_value !== 8'h00) begin n_errors++; $display("FAIL wrap_last got=%h exp=00", last_value); end
    if (err_count !== 4'd0) begin n_errors++; $display("FAIL wrap_errcnt got=%0d exp=0", err_count); end
  endtask

  task automatic test_bad_jump();
    for (int unsigned i = 1; i <= 5; i++) step(0, 1, 0, W'(i));
    step(0, 1, 0, 8'h07);
    #1; n_checks += 3;
    if (err_pulse !== 1'b1) begin n_errors++; $display("FAIL bad_pulse got=%b exp=1", err_pulse); end
    if (err_count !== 4'd1) begin n_errors++; $display("FAIL bad_errcnt got=%0d exp=1", err_count); end
    if (locked !== 1'b0) begin n_errors++; $display("FAIL bad_unlock got=%b exp=0", locked); end
    step(0, 1, 0, 8'h07);
    #1; n_checks++;
    if (err_pulse !== 1'b0) begin n_errors++; $display("FAIL bad_pulse_width got=%b exp=0", err_pulse); end
    step(0, 1, 0, 8'h08);
    #1; n_checks += 2;
    if (locked !== 1'b1) begin n_errors++; $display("FAIL bad_relock got=%b exp=1", locked); end
    if (err_count !== 4'd1) begin n_errors++; $display("FAIL bad_errcnt_hold got=%0d exp=1", err_count); end
  endtask

  task automatic test_stall();
    for (int unsigned i = 9; i <= 16; i++) step(0, 1, 0, W'(i));
    for (int i = 1; i <= 15; i++) step(0, 1, 0, 8'h10);
    #1; n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL stall_early got=%b exp=0", stall); end
    step(0, 1, 0, 8'h10);
    #1; n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL stall_at_limit got=%b exp=1", stall); end
    step(0, 1, 0, 8'h11);
    #1; n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL stall_clear_on_inc got=%b exp=0", stall); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 100; i++) step(0, 0, (i % 7) == 0, W'($urandom_range(0, 255)));
    #1; n_checks += 4;
    if (err_count !== 4'd1) begin n_errors++; $display("FAIL freeze_errcnt got=%0d exp=1", err_count); end
    if (stall !== 1'b0) begin n_errors++; $display("FAIL freeze_stall got=%b exp=0", stall); end
    if (last_value !== 8'h11) begin n_errors++; $display("FAIL freeze_last got=%h exp=11", last_value); end
    if (locked !== 1'b1) begin n_errors++; $display("FAIL freeze_locked got=%b exp=1", locked); end
  endtask

  task automatic test_clr_vs_stall();
    for (int i = 1; i <= 16; i++) step(0, 1, i == 16, 8'h11);
    #1; n_checks += 2;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL clr_stall_coincident got=%b exp=1", stall); end
    if (err_count !== 4'd0) begin n_errors++; $display("FAIL clr_errcnt got=%0d exp=0", err_count); end
    step(0, 1, 0, 8'h12);
  endtask

  task automatic test_saturation();
    v = 8'h12;
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, v + 8'd2);
      step(0, 1, 0, v + 8'd3);
      v = v + 8'd3;
    end
    #1; n_checks += 2;
    if (err_count !== 4'd15) begin n_errors++; $display("FAIL sat_errcnt got=%0d exp=15", err_count); end
    if (locked !== 1'b1) begin n_errors++; $display("FAIL sat_relocked got=%b exp=1", locked); end
    step(0, 1, 1, v + 8'd2);
    #1; n_checks++;
    if (err_count !== 4'd1) begin n_errors++; $display("FAIL clr_with_err got=%0d exp=1", err_count); end
    step(0, 1, 0, v + 8'd3);
    v = v + 8'd3;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, v + 8'd2);
      step(0, 1, 0, v + 8'd3);
      v = v + 8'd3;
    end
    for (int i = 0; i < 16; i++) step(0, 1, 0, v);
    #1; n_checks += 3;
    if (err_count !== 4'd3) begin n_errors++; $display("FAIL pre_rst_errcnt got=%0d exp=3", err_count); end
    if (stall !== 1'b1) begin n_errors++; $display("FAIL pre_rst_stall got=%b exp=1", stall); end
    if (locked !== 1'b1) begin n_errors++; $display("FAIL pre_rst_locked got=%b exp=1", locked); end
    step(1, 0, 1, v + 8'd1);
    #1; n_checks++;
    if ({locked, err_pulse, err_count, stall, last_value} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset got=%b/%b/%0d/%b/%h exp=all zero", locked, err_pulse, err_count, stall, last_value);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap_back_to_back();
    test_bad_jump();
    test_stall();
    test_freeze();
    test_clr_vs_stall();
    test_saturation();
    test_reset_mid();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
